// File: rtl/mips_arith_unit.sv
// Arithmetic block for the 5-stage MIPS pipeline: IF PC+4, ID branch target, EX ALU.
// All datapath outputs are combinational; the only state is a sticky overflow flag.
module mips_arith_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] pc4_id,
    input  logic [WIDTH-1:0] br_offset,
    output logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_result,
    output logic             overflow,
    output logic             ovf_sticky
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SLL = 3'b011,
        OP_SRL = 3'b100,
        OP_NOR = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } aluOp_e;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] sumAb;
    logic [WIDTH-1:0] diffAb;
    logic             signA;
    logic             signB;
    logic             addOvf;
    logic             subOvf;
    logic             sltBit;

    // Both adders wrap modulo 2^WIDTH; carry out is deliberately dropped.
    assign pc_plus4  = pc_in + PC_STEP;
    assign br_target = pc4_id + br_offset;

    assign sumAb  = alu_a + alu_b;
    assign diffAb = alu_a - alu_b;
    assign signA  = alu_a[WIDTH-1];
    assign signB  = alu_b[WIDTH-1];

    assign addOvf = (signA == signB) && (sumAb[WIDTH-1] != signA);
    assign subOvf = (signA != signB) && (diffAb[WIDTH-1] != signA);

    // Equals the sign of the (WIDTH+1)-bit difference: when signs differ the
    // negative operand is smaller, otherwise the WIDTH-bit difference cannot overflow.
    assign sltBit = (signA != signB) ? signA : diffAb[WIDTH-1];

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (aluOp_e'(alu_op))
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_ADD: begin
                alu_result = sumAb;
                overflow   = addOvf;
            end
            OP_SLL: alu_result = alu_b << shamt;
            OP_SRL: alu_result = alu_b >> shamt;
            OP_NOR: alu_result = ~(alu_a | alu_b);
            OP_SUB: begin
                alu_result = diffAb;
                overflow   = subOvf;
            end
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, sltBit};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_sticky | overflow;
        end
    end

endmodule

// File: tb/tb_mips_arith_unit.sv
// Directed-vector bench for mips_arith_unit: the driver pushes hand-computed
// expectations into queues, and a negedge monitor pops and compares them.
module tb_mips_arith_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] pcIn;
    logic [W-1:0] pcPlus4;
    logic [W-1:0] pc4Id;
    logic [W-1:0] brOffset;
    logic [W-1:0] brTarget;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [4:0]   shamt;
    logic [2:0]   aluOp;
    logic [W-1:0] aluResult;
    logic         overflow;
    logic         ovfSticky;

    logic [W-1:0] expQ[$];
    logic [W-1:0] expPc4Q[$];
    logic [W-1:0] expBrQ[$];
    logic         expOvfQ[$];
    logic         expStickyQ[$];

    int  testsRun = 0;
    int  testsFailed = 0;
    logic monValid = 1'b0;

    logic stickyModel = 1'b0;
    logic prevRst = 1'b1;
    logic prevOvf = 1'b0;

    mips_arith_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pcIn),
        .pc_plus4   (pcPlus4),
        .pc4_id     (pc4Id),
        .br_offset  (brOffset),
        .br_target  (brTarget),
        .alu_a      (aluA),
        .alu_b      (aluB),
        .shamt      (shamt),
        .alu_op     (aluOp),
        .alu_result (aluResult),
        .overflow   (overflow),
        .ovf_sticky (ovfSticky)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Driver: one vector per cycle. Sticky expectation follows from the
    // previous cycle's reset and overflow, which the DUT captures this edge.
    task automatic applyVec(
        input logic         rstV,
        input logic [W-1:0] pcV,
        input logic [W-1:0] pc4V,
        input logic [W-1:0] offV,
        input logic [W-1:0] aV,
        input logic [W-1:0] bV,
        input logic [4:0]   shV,
        input logic [2:0]   opV,
        input logic [W-1:0] expRes,
        input logic         expOvf,
        input logic [W-1:0] expPc4,
        input logic [W-1:0] expBr
    );
        logic stickyNow;
        @(posedge clk);
        #1;
        stickyNow   = prevRst ? 1'b0 : (stickyModel | prevOvf);
        stickyModel = stickyNow;
        prevRst     = rstV;
        prevOvf     = expOvf;
        rst      = rstV;
        pcIn     = pcV;
        pc4Id    = pc4V;
        brOffset = offV;
        aluA     = aV;
        aluB     = bV;
        shamt    = shV;
        aluOp    = opV;
        expQ.push_back(expRes);
        expOvfQ.push_back(expOvf);
        expPc4Q.push_back(expPc4);
        expBrQ.push_back(expBr);
        expStickyQ.push_back(stickyNow);
        monValid = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (monValid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                check("alu_result", aluResult, expQ.pop_front());
                check("overflow", {31'b0, overflow}, {31'b0, expOvfQ.pop_front()});
                check("pc_plus4", pcPlus4, expPc4Q.pop_front());
                check("br_target", brTarget, expBrQ.pop_front());
                check("ovf_sticky", {31'b0, ovfSticky}, {31'b0, expStickyQ.pop_front()});
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1;
        pcIn = '0; pc4Id = '0; brOffset = '0;
        aluA = '0; aluB = '0; shamt = '0; aluOp = 3'b000;
        repeat (3) @(posedge clk);

        // rst pc pc4 off a b sh op | res ovf pc+4 target
        applyVec(0, 32'h0040_0000, 32'h0040_0008, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 3'b010,
                 32'h8000_0000, 1, 32'h0040_0004, 32'h003F_FFF8);
        applyVec(0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0005, 32'h0000_0007, 5'd0, 3'b110,
                 32'hFFFF_FFFE, 0, 32'h0000_0000, 32'h0000_0004);
        applyVec(1, 32'h0000_0010, 32'h0000_0100, 32'h0000_0020, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 3'b000,
                 32'hF000_F000, 0, 32'h0000_0014, 32'h0000_0120);
        applyVec(0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0008, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 3'b001,
                 32'hFFF0_FFF0, 0, 32'h1234_567C, 32'h0000_0004);
        applyVec(0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 3'b101,
                 32'h000F_000F, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 5'd0, 3'b111,
                 32'h0000_0001, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 5'd0, 3'b111,
                 32'h0000_0000, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, 3'b011,
                 32'h8000_0000, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 5'd31, 3'b100,
                 32'h0000_0001, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 3'b011,
                 32'h1234_5678, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 5'd0, 3'b110,
                 32'h7FFF_FFFF, 1, 32'h0000_0004, 32'h0000_0000);
        // Reset coincides with an overflowing ADD: reset must win.
        applyVec(1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 5'd0, 3'b010,
                 32'h0000_0000, 1, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 3'b010,
                 32'h0000_0000, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hF000_0000, 5'd4, 3'b100,
                 32'h0F00_0000, 0, 32'h0000_0004, 32'h0000_0000);
        applyVec(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 3'b111,
                 32'h0000_0000, 0, 32'h0000_0004, 32'h0000_0000);

        @(posedge clk);
        #1;
        monValid = 1'b0;

        budget = 20;
        while (expQ.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
